// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Each queue entry pairs a fetched word with the PC it came from.
package instr_fetch_queue_pkg;

    localparam int          PC_WIDTH       = 32;
    localparam int          INSTR_WIDTH    = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam int          INSTR_TYPE_MSB = 31;
    localparam int          INSTR_TYPE_LSB = 27;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [PC_WIDTH-1:0]    pc,
                                                input logic [INSTR_WIDTH-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: memory read port 0, redirect input and issue-stage handshake.
// The master side is the fetch queue; the slave side is the surrounding core.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             fetch_en;
    logic [31:0]      imem_raddr;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             issue_ready;
    logic             issue_valid;
    logic [31:0]      issue_instr;
    logic [31:0]      issue_pc;
    logic [OCC_W-1:0] occupancy;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, issue_ready,
        output imem_raddr, issue_valid, issue_instr, issue_pc, occupancy
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, issue_ready,
        input  imem_raddr, issue_valid, issue_instr, issue_pc, occupancy
    );

endinterface

// File: rtl/fetch_fifo_storage.sv
// In-order DEPTH-entry storage for {pc, instr} pairs with read/write pointers and count.
// Entry contents are never reset; only pointers and count are, so head is meaningful only when count != 0.
module fetch_fifo_storage
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             full_s;

    // Guard the handshakes locally so no caller can underflow or overflow the array.
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Entry write port; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok_s & ~clr & ~rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads memory port 0 with it and queues {pc, word} for issue.
// A redirect flushes the queue and reloads the PC; issue outputs come only from stored entries.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_queue_if.master   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc_r;
    logic [CNT_W-1:0]    count_s;
    fetch_entry_t        head_s;
    fetch_entry_t        wentry_s;
    logic                valid_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;

    assign valid_s  = (count_s != {CNT_W{1'b0}});
    assign full_s   = (count_s == CNT_W'(DEPTH));
    assign pop_s    = valid_s & bus.issue_ready;
    // A full queue still accepts a word in a cycle where the head leaves.
    assign push_s   = bus.fetch_en & ~bus.redirect_valid & (~full_s | pop_s);
    assign wentry_s = make_entry(fetch_pc_r, bus.imem_rdata);

    fetch_fifo_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wentry_s),
        .head  (head_s),
        .count (count_s)
    );

    // Program counter: reset, then redirect, then sequential advance (wraps at 2^32).
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc_r <= bus.redirect_pc;
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd1;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Mask the head so an empty queue presents a NO-OP at PC 0.
    always_comb begin
        bus.issue_instr = NOP_INSTR;
        bus.issue_pc    = 32'h0000_0000;
        if (valid_s) begin
            bus.issue_instr = head_s.instr;
            bus.issue_pc    = head_s.pc;
        end else begin
            bus.issue_instr = NOP_INSTR;
            bus.issue_pc    = 32'h0000_0000;
        end
    end

    assign bus.imem_raddr  = fetch_pc_r;
    assign bus.issue_valid = valid_s;
    assign bus.occupancy   = count_s;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a queue-of-{pc,word} reference model fed by the
// stimulus process, and a monitor that checks every cycle and pops on each issued word.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFE;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } tb_entry_t;

    logic clk;
    logic rst;

    instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tb_entry_t   sb[$];
    logic [31:0] model_pc;
    int          n_checks;
    int          n_pass;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_raddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare presented outputs against the model, pop on every consumed word.
    initial begin
        tb_entry_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("occupancy", 32'(bus.occupancy), 32'(sb.size()));
            chk("issue_valid", 32'(bus.issue_valid), 32'(sb.size() != 0));
            chk("imem_raddr", bus.imem_raddr, model_pc);
            if (bus.issue_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_issue", 32'(bus.issue_valid), 32'd0);
                end else begin
                    e = sb[0];
                    chk("issue_pc", bus.issue_pc, e.pc);
                    chk("issue_instr", bus.issue_instr, e.instr);
                    if (bus.issue_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("empty_instr", bus.issue_instr, 32'h0);
                chk("empty_pc", bus.issue_pc, 32'h0);
            end
        end
    end

    // One cycle of stimulus; the model advances after the monitor has seen this cycle.
    task automatic step(input logic r, input logic fen, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        int   sz;
        logic pop_m;
        logic push_m;
        @(negedge clk);
        rst                = r;
        bus.fetch_en       = fen;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.issue_ready    = rdy;
        sz     = sb.size();
        pop_m  = (sz != 0) && rdy;
        push_m = fen && !rv && ((sz < DEPTH) || pop_m);
        #2;
        if (r) begin
            sb.delete();
            model_pc = RESET_PC;
        end else if (rv) begin
            sb.delete();
            model_pc = rpc;
        end else if (push_m) begin
            sb.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] rpc;
        n_checks           = 0;
        n_pass             = 0;
        model_pc           = RESET_PC;
        rst                = 1'b1;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.issue_ready    = 1'b0;

        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // Streaming from reset across the 32-bit PC wrap.
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        // Fill with issue stalled, then drain while fetching without a gap.
        step(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        // Redirect with PCs 5..7 queued.
        step(1'b0, 1'b1, 1'b1, 32'h5, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        // Full queue, redirect together with a pop; nothing stale afterwards.
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        // fetch_en low: PC frozen while the queue drains.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Reset mid-operation with occupancy 3 and PC 9.
        step(1'b0, 1'b1, 1'b1, 32'h6, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            end else begin
                rpc = 32'($urandom_range(0, 255));
            end
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 19) == 0),
                 rpc,
                 1'($urandom_range(0, 9) < 6));
        end

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage that sits directly upstream of the issue register in the pipelined core.
- Owns the program counter and drives main-memory read port 0 with it.
- Buffers fetched words with their PCs in a small in-order queue and presents the head to the issue stage.
- Decouples fetch from issue stalls; execute-stage jumps flush the queue and redirect the PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  fetch permitted; 0 freezes PC and enqueue, issue side keeps draining.
- imem_raddr  output  32  read address to main memory port 0 (combinational read, data back same cycle).
- imem_rdata  input  32  instruction word returned for imem_raddr.
- redirect_valid  input  1  jump taken; flush the queue and load redirect_pc.
- redirect_pc  input  32  jump target.
- issue_ready  input  1  issue register accepts this cycle (driven as !stall).
- issue_valid  output  1  head entry present.
- issue_instr  output  32  head instruction; 32'h0 (NO-OP) when empty.
- issue_pc  output  32  PC of head instruction; 32'h0 when empty.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset: fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0. Outputs go to issue_valid=0, issue_instr=0, issue_pc=0, occupancy=0, imem_raddr=RESET_PC. Applies mid-operation; all in-flight entries are discarded.
- imem_raddr = fetch_pc, driven combinationally from the PC register.
- pop = issue_valid & issue_ready.
- push = fetch_en & !redirect_valid & (count<DEPTH | pop). A full queue accepts a push in the same cycle it pops.
- On push:
  - entry[wr_ptr] <= {fetch_pc, imem_rdata}.
  - wr_ptr++ (mod DEPTH).
  - fetch_pc <= fetch_pc+1, wrapping 32'hFFFFFFFF to 0.
- On pop: rd_ptr++ (mod DEPTH).
- count update: count += push - pop.
- Redirect has priority over everything:
  - count<=0, rd_ptr<=wr_ptr<=0, fetch_pc<=redirect_pc.
  - No push that cycle.
  - A pop asserted in the redirect cycle still counts as consumed by the issue stage, but the queue is cleared regardless.
- Outputs are read from registered storage only; there is no bypass from imem_rdata to issue_instr.
  - Fetch-to-issue latency is 1 cycle: a word pushed at edge N is issue_valid after edge N.
  - Throughput is 1 instruction/cycle when issue_ready is held high.
- issue_valid = (count!=0). issue_instr and issue_pc come from entry[rd_ptr] when valid, else 0.
- issue_ready is ignored when empty; no underflow. No push occurs when full without a pop; no overflow.
- fetch_en=0: PC holds, imem_raddr is stable, the queue drains normally.
- Storage contents are not reset. Only pointers and count are reset; the outputs are masked by issue_valid.

Decomposition:
- arch_defines.v gains:
  - `NOP_INSTR 32'h0
  - `PC_WIDTH 32
  - `INSTR_TYPE_RANGE 31:27
- One sub-module, fetch_fifo_storage:
  - DEPTH x 64-bit register array with pointers and count.
  - Synchronous clear input used for redirect/reset.
  - push/pop interface plus head data and count.
- instr_fetch_queue holds the PC register and push/pop/redirect control.

Test Plan:
1. Reset then fetch_en=1, issue_ready=1, mem[0..3]=A,B,C,D -> issue_instr A,B,C,D on consecutive cycles from the cycle after the first edge; issue_pc 0,1,2,3; occupancy steady at 1.
2. issue_ready=0 for 6 cycles from reset -> occupancy 1,2,3,4,4,4; imem_raddr stops at 4. Then issue_ready=1 -> pops A..D in order, and push resumes the same cycle (occupancy stays 4 while fetching) with no gap.
3. Queue holding PCs 5..7, redirect_valid=1 with redirect_pc=32'h40 -> next cycle issue_valid=0, issue_instr=0, imem_raddr=32'h40; one cycle later issue_pc=32'h40.
4. Full queue with simultaneous redirect and issue_ready=1 -> queue empty, occupancy=0, no stale entry issued afterward.
5. Start at RESET_PC=32'hFFFFFFFE -> issue_pc sequence FFFFFFFE, FFFFFFFF, 0, 1.
6. rst asserted while occupancy=3 and fetch_pc=9 -> next cycle occupancy=0, issue_valid=0, imem_raddr=RESET_PC.
